// File: rtl/dmem_rmw_ctrl.sv
// Data-memory access controller: byte/half/word loads and stores
// over a word-wide SRAM, with read-modify-write for sub-word stores.
module dmem_rmw_ctrl #(
  parameter int ram_width = 32,
  parameter int ram_add   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic [ram_add+1:0]   addr_i,
  input  logic [ram_width-1:0] din_i,
  input  logic [1:0]           data_format_i,
  input  logic                 data_sign_i,
  output logic                 ready_o,
  output logic [ram_width-1:0] dout_o,
  output logic                 valid_o,
  output logic                 err_o,
  output logic                 mem_en_o,
  output logic                 mem_we_o,
  output logic [ram_add-1:0]   mem_addr_o,
  output logic [ram_width-1:0] mem_wdata_o,
  input  logic [ram_width-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    RDATA,
    WRITE
  } state_t;

  localparam logic [1:0] FMT_B = 2'b00;
  localparam logic [1:0] FMT_H = 2'b01;
  localparam logic [1:0] FMT_W = 2'b10;

  state_t               state_q, state_d;
  logic                 we_q, we_d;
  logic [ram_add+1:0]   addr_q, addr_d;
  logic [ram_width-1:0] din_q, din_d;
  logic [1:0]           fmt_q, fmt_d;
  logic                 sign_q, sign_d;
  logic [ram_width-1:0] dout_q, dout_d;
  logic [ram_width-1:0] merge_q, merge_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;

  logic                 bad_req;
  int                   bsh, hsh;
  logic [7:0]           bsel;
  logic [15:0]          hsel;
  logic [ram_width-1:0] ext;
  logic [ram_width-1:0] mask;
  logic [ram_width-1:0] ins;
  logic [ram_width-1:0] merged;

  // Misaligned or reserved-format requests are refused up front.
  always_comb begin
    bad_req = 1'b0;
    unique case (data_format_i)
      FMT_B:   bad_req = 1'b0;
      FMT_H:   bad_req = addr_i[0];
      FMT_W:   bad_req = |addr_i[1:0];
      default: bad_req = 1'b1;
    endcase
  end

  // Lane select (big-endian): extract for loads, merge for stores.
  always_comb begin
    bsh  = ram_width - 8 - 8 * int'(addr_q[1:0]);
    hsh  = ram_width - 16 - 16 * int'(addr_q[1]);
    bsel = 8'(mem_rdata_i >> bsh);
    hsel = 16'(mem_rdata_i >> hsh);
    unique case (fmt_q)
      FMT_B:   ext = {{(ram_width-8){sign_q & bsel[7]}}, bsel};
      FMT_H:   ext = {{(ram_width-16){sign_q & hsel[15]}}, hsel};
      default: ext = mem_rdata_i;
    endcase
    if (fmt_q == FMT_B) begin
      mask = {{(ram_width-8){1'b0}}, 8'hFF} << bsh;
      ins  = {{(ram_width-8){1'b0}}, din_q[7:0]} << bsh;
    end else begin
      mask = {{(ram_width-16){1'b0}}, 16'hFFFF} << hsh;
      ins  = {{(ram_width-16){1'b0}}, din_q[15:0]} << hsh;
    end
    merged = (mem_rdata_i & ~mask) | ins;
  end

  // Next-state and datapath updates of the access FSM.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    din_d   = din_q;
    fmt_d   = fmt_q;
    sign_d  = sign_q;
    dout_d  = dout_q;
    merge_d = merge_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en_i && !done_q) begin
          if (bad_req) begin
            err_d = 1'b1;
          end else begin
            we_d   = we_i;
            addr_d = addr_i;
            din_d  = din_i;
            fmt_d  = data_format_i;
            sign_d = data_sign_i;
            if (we_i && data_format_i == FMT_W)
              state_d = WRITE;
            else
              state_d = READ;
          end
        end
      end
      READ: state_d = RDATA;
      RDATA: begin
        if (we_q) begin
          merge_d = merged;
          state_d = WRITE;
        end else begin
          dout_d  = ext;
          valid_d = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      WRITE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any access.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      fmt_q   <= FMT_B;
      sign_q  <= 1'b0;
      dout_q  <= '0;
      merge_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      fmt_q   <= fmt_d;
      sign_q  <= sign_d;
      dout_q  <= dout_d;
      merge_q <= merge_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // The cycle right after completion is idle but not yet accepting.
  assign ready_o     = (state_q == IDLE) && !done_q;
  assign dout_o      = dout_q;
  assign valid_o     = valid_q;
  assign err_o       = err_q;
  assign mem_en_o    = (state_q == READ) || (state_q == WRITE);
  assign mem_we_o    = (state_q == WRITE);
  assign mem_addr_o  = addr_q[ram_add+1:2];
  assign mem_wdata_o = (fmt_q == FMT_W) ? din_q : merge_q;

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Bench for dmem_rmw_ctrl: SRAM model plus byte-addressed
// big-endian reference memory, directed and random accesses.
module tb_dmem_rmw_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic        we_i;
  logic [9:0]  addr_i;
  logic [31:0] din_i;
  logic [1:0]  data_format_i;
  logic        data_sign_i;
  logic        ready_o;
  logic [31:0] dout_o;
  logic        valid_o;
  logic        err_o;
  logic        mem_en_o;
  logic        mem_we_o;
  logic [7:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  dmem_rmw_ctrl #(.ram_width(32), .ram_add(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .we_i(we_i),
    .addr_i(addr_i), .din_i(din_i),
    .data_format_i(data_format_i), .data_sign_i(data_sign_i),
    .ready_o(ready_o), .dout_o(dout_o), .valid_o(valid_o),
    .err_o(err_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  logic [31:0] sram [256];
  logic [7:0]  rb [1024];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          vl_cnt = 0;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] last_dout;

  always @(posedge clk) begin
    if (mem_en_o && !mem_we_o) begin
      mem_rdata_i <= sram[mem_addr_o];
      rd_cnt <= rd_cnt + 1;
    end
    if (mem_en_o && mem_we_o) begin
      sram[mem_addr_o] <= mem_wdata_o;
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= mem_addr_o;
      wr_data <= mem_wdata_o;
    end
    if (valid_o) vl_cnt <= vl_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {rb[4*w], rb[4*w+1], rb[4*w+2], rb[4*w+3]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [9:0] a,
                                           input logic [1:0] f,
                                           input bit s);
    logic [7:0]  b;
    logic [15:0] h;
    b = rb[a];
    h = {rb[a], rb[a+10'd1]};
    case (f)
      2'b00:   return s ? {{24{b[7]}}, b} : {24'h0, b};
      2'b01:   return s ? {{16{h[15]}}, h} : {16'h0, h};
      default: return ref_word(int'(a[9:2]));
    endcase
  endfunction

  task automatic set_word(input int w, input logic [31:0] v);
    sram[w] = v;
    rb[4*w] = v[31:24];
    rb[4*w+1] = v[23:16];
    rb[4*w+2] = v[15:8];
    rb[4*w+3] = v[7:0];
  endtask

  task automatic wait_ready();
    int i;
    i = 0;
    while (!ready_o && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk("wait_ready", 32'(ready_o), 32'd1);
  endtask

  task automatic access(input bit we, input logic [9:0] a,
                        input logic [31:0] d, input logic [1:0] f,
                        input bit s);
    bit          bad;
    int          nb, low, vk, ek, vn, en_n, rd0, wr0;
    int          exp_low, exp_rd;
    logic [31:0] exp_d;
    bad = (f == 2'b11) || (f == 2'b01 && a[0]) ||
          (f == 2'b10 && a[1:0] != 2'b00);
    nb = (f == 2'b00) ? 1 : (f == 2'b01) ? 2 : 4;
    exp_d = (!bad && !we) ? ref_load(a, f, s) : last_dout;
    exp_low = bad ? 0 : !we ? 3 : (f == 2'b10) ? 2 : 4;
    exp_rd = (bad || (we && f == 2'b10)) ? 0 : 1;
    wait_ready();
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    en_i = 1'b1;
    we_i = we;
    addr_i = a;
    din_i = d;
    data_format_i = f;
    data_sign_i = s;
    @(posedge clk);
    #1 en_i = 1'b0;
    din_i = $urandom;
    low = 0; vk = 0; ek = 0; vn = 0; en_n = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (valid_o) begin vk = k; vn++; end
      if (err_o) begin ek = k; en_n++; end
      if (!ready_o) low++;
      else break;
    end
    chk("busy_cycles", 32'(low), 32'(exp_low));
    chk("err_at", 32'(ek), bad ? 32'd1 : 32'd0);
    chk("err_pulses", 32'(en_n), bad ? 32'd1 : 32'd0);
    chk("valid_at", 32'(vk), (!bad && !we) ? 32'd3 : 32'd0);
    chk("valid_pulses", 32'(vn), (!bad && !we) ? 32'd1 : 32'd0);
    chk("dout", dout_o, exp_d);
    chk("sram_reads", 32'(rd_cnt - rd0), 32'(exp_rd));
    chk("sram_writes", 32'(wr_cnt - wr0), (!bad && we) ? 32'd1 : 32'd0);
    last_dout = exp_d;
    if (!bad && we) begin
      for (int i = 0; i < nb; i++)
        rb[a + 10'(i)] = d[8*(nb-1-i) +: 8];
      chk("wr_addr", 32'(wr_addr), 32'(a[9:2]));
      chk("wr_data", wr_data, ref_word(int'(a[9:2])));
    end
  endtask

  initial begin
    int r0, v0, w0;
    for (int w = 0; w < 256; w++) set_word(w, $urandom);
    set_word(4, 32'h8899AABB);
    rst_i = 1'b1;
    en_i = 1'b0;
    we_i = 1'b0;
    addr_i = '0;
    din_i = '0;
    data_format_i = 2'b00;
    data_sign_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_dout", dout_o, 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_mem_en", 32'(mem_en_o), 32'd0);
    chk("rst_mem_we", 32'(mem_we_o), 32'd0);
    rst_i = 1'b0;
    last_dout = 32'd0;

    access(1'b0, 10'h11, 32'h0, 2'b00, 1'b1);
    chk("ld_b_s_11", dout_o, 32'hFFFFFF99);
    access(1'b0, 10'h12, 32'h0, 2'b01, 1'b0);
    chk("ld_h_u_12", dout_o, 32'h0000AABB);
    access(1'b0, 10'h10, 32'h0, 2'b10, 1'b0);
    chk("ld_w_10", dout_o, 32'h8899AABB);
    access(1'b1, 10'h13, 32'h0000005A, 2'b00, 1'b0);
    chk("st_b_13", sram[4], 32'h8899AA5A);
    access(1'b0, 10'h12, 32'h0, 2'b10, 1'b0);
    chk("misalign_dout", dout_o, 32'h8899AABB);

    wait_ready();
    w0 = wr_cnt;
    en_i = 1'b1;
    we_i = 1'b1;
    addr_i = 10'h10;
    din_i = 32'h1234;
    data_format_i = 2'b01;
    @(posedge clk);
    #1 en_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    chk("rmw_rst_ready", 32'(ready_o), 32'd1);
    chk("rmw_rst_mem_en", 32'(mem_en_o), 32'd0);
    chk("rmw_rst_dout", dout_o, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rmw_rst_nowrite", 32'(wr_cnt - w0), 32'd0);
    chk("rmw_rst_word4", sram[4], 32'h8899AA5A);
    last_dout = 32'd0;
    access(1'b0, 10'h10, 32'h0, 2'b10, 1'b0);

    wait_ready();
    r0 = rd_cnt;
    v0 = vl_cnt;
    en_i = 1'b1;
    we_i = 1'b0;
    addr_i = 10'h14;
    data_format_i = 2'b10;
    repeat (12) @(posedge clk);
    @(negedge clk);
    en_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("hold_reads", 32'(rd_cnt - r0), 32'd3);
    chk("hold_valids", 32'(vl_cnt - v0), 32'd3);
    chk("hold_dout", dout_o, ref_word(5));
    last_dout = ref_word(5);

    for (int n = 0; n < 40; n++) begin
      logic [9:0] a;
      a = 10'($urandom_range(0, 31));
      access(1'($urandom_range(0, 1)), a, $urandom,
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    for (int w = 0; w < 8; w++)
      chk($sformatf("final_word%0d", w), sram[w], ref_word(w));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_rmw_ctrl.md
DMEM_RMW_CTRL -- requirements
Module: dmem_rmw_ctrl

Interface
REQ-001 SHALL have parameter ram_width, default 32, data word width in bits.
REQ-002 SHALL have parameter ram_add, default 8, word-address width of the backing SRAM.
REQ-003 SHALL have port clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en_i  input  1  CPU data access request.
REQ-006 SHALL have port we_i  input  1  1 = store, 0 = load.
REQ-007 SHALL have port addr_i  input  ram_add+2  byte address.
REQ-008 SHALL have port din_i  input  ram_width  store data, right-justified.
REQ-009 SHALL have port data_format_i  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-010 SHALL have port data_sign_i  input  1  1 = sign-extend loads, 0 = zero-extend.
REQ-011 SHALL have port ready_o  output  1  controller idle and accepting requests.
REQ-012 SHALL have port dout_o  output  ram_width  load result.
REQ-013 SHALL have port valid_o  output  1  one-cycle pulse, dout_o updated.
REQ-014 SHALL have port err_o  output  1  one-cycle pulse, rejected request.
REQ-015 SHALL have port mem_en_o  output  1  SRAM enable.
REQ-016 SHALL have port mem_we_o  output  1  SRAM write enable.
REQ-017 SHALL have port mem_addr_o  output  ram_add  SRAM word address, equal to latched addr_i[ram_add+1:2].
REQ-018 SHALL have port mem_wdata_o  output  ram_width  SRAM write data.
REQ-019 SHALL have port mem_rdata_i  input  ram_width  SRAM read data, valid the cycle after a read-enabled cycle.

Function
REQ-020 SHALL be a Moore FSM with states IDLE, READ, RDATA, WRITE; ready_o=1 only in IDLE.
REQ-021 SHALL sample en_i only in IDLE; requests while ready_o=0 are ignored, never queued.
REQ-022 SHALL latch we_i, addr_i, din_i, data_format_i and data_sign_i on the accepting edge.
REQ-023 SHALL reject a misaligned request (half with addr_i[0]=1, word with addr_i[1:0]!=0) or format 11: err_o pulses the next cycle, state stays IDLE, no SRAM access.
REQ-024 SHALL transition for a load IDLE->READ->RDATA->IDLE; the SRAM read is issued in READ (mem_en_o=1, mem_we_o=0).
REQ-025 SHALL, on exit from RDATA for a load, register the extracted and extended value in dout_o and pulse valid_o; result is visible 3 cycles after the accepting edge.
REQ-026 SHALL use big-endian lane order: byte offset 0 = bits 31:24, 3 = bits 7:0; half offset 0 = bits 31:16, 2 = bits 15:0.
REQ-027 SHALL sign- or zero-extend byte/half loads per the latched sign bit; word loads pass unchanged.
REQ-028 SHALL transition for a word store IDLE->WRITE->IDLE, with mem_wdata_o = latched din.
REQ-029 SHALL transition for a byte/half store IDLE->READ->RDATA->WRITE->IDLE (read-modify-write): target lane(s) replaced with din low bits, other lanes kept from mem_rdata_i, merged word held in a register and driven in WRITE.
REQ-030 SHALL hold mem_en_o=mem_we_o=0 in IDLE and RDATA; mem_we_o=1 only in WRITE.
REQ-031 SHALL hold dout_o at its last value except on a load completion; stores never change dout_o or pulse valid_o.
REQ-032 SHALL accept a new request in the same edge that returns to IDLE only in the following cycle (no back-to-back bypass).

Reset
REQ-033 SHALL, when rst_i=1 at an edge, force state=IDLE, dout_o=0, valid_o=0, err_o=0, merge register=0; ready_o=1, mem_en_o=0, mem_we_o=0 after that edge.
REQ-034 SHALL abandon any in-flight access on reset (no SRAM write issued, no valid_o), including mid read-modify-write.
REQ-035 SHALL have rst_i take priority over en_i at the same edge.

Verification
REQ-036 SHALL cover: SRAM word 4 = 0x8899AABB, load byte signed addr 0x11 -> dout_o=0xFFFFFF99, valid_o 3 cycles after accept.
REQ-037 SHALL cover: same word, load half unsigned addr 0x12 -> dout_o=0x0000AABB; load word addr 0x10 -> 0x8899AABB.
REQ-038 SHALL cover: store byte din=0x0000005A addr 0x13 -> single SRAM write of 0x8899AA5A to word 4, ready_o low 4 cycles.
REQ-039 SHALL cover: load word addr 0x12 -> err_o one pulse, mem_en_o stays 0, dout_o unchanged.
REQ-040 SHALL cover: store half addr 0x10, rst_i asserted during RDATA -> no mem_we_o pulse, word 4 unchanged, ready_o=1 after the reset edge.
REQ-041 SHALL cover: en_i held high while busy -> exactly one access per IDLE acceptance, none lost or duplicated.
